// File: rtl/uart_frame_rx.sv
// uart_frame_rx: hunts a preamble, gathers a payload plus optional sum checksum,
// and publishes it atomically with inter-byte timeout and error reporting.
module uart_frame_rx #(
    parameter logic [7:0] PREAMBLE_BYTE  = 8'hFF,
    parameter int         PREAMBLE_LEN   = 4,
    parameter int         PAYLOAD_BYTES  = 10,
    parameter int         CHECKSUM_EN    = 1,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_done,
    input  logic [7:0]                 current_rx,
    output logic [8*PAYLOAD_BYTES-1:0] frame_data,
    output logic                       frame_valid,
    output logic                       frame_err,
    output logic [1:0]                 err_code,
    output logic [15:0]                frame_count,
    output logic [15:0]                err_count
);
    localparam int IW = $clog2(PAYLOAD_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {SYNC, PAYLOAD, CHECK} state_t;

    state_t                     state;
    logic [3:0]                 pre_cnt;
    logic [IW-1:0]              idx;
    logic [7:0]                 sum;
    logic [TW-1:0]              timer;
    logic [8*PAYLOAD_BYTES-1:0] staging;
    logic [8*PAYLOAD_BYTES-1:0] staged;
    logic                       last;
    logic                       run;
    logic                       expire;
    logic                       good;
    logic                       bad;
    logic                       fail;

    // staging with the current byte merged in, so a checksum-less frame can publish its last byte
    always_comb begin
        staged = staging;
        if (state == PAYLOAD) staged[8*int'(idx) +: 8] = current_rx;
    end

    assign last   = idx == IW'(PAYLOAD_BYTES - 1);
    assign run    = state != SYNC || pre_cnt != 4'd0;
    assign expire = !rx_done && run && timer == TW'(TIMEOUT_CYCLES - 1);
    assign good   = rx_done && ((state == PAYLOAD && last && CHECKSUM_EN == 0) ||
                                (state == CHECK && current_rx == sum));
    assign bad    = rx_done && state == CHECK && current_rx != sum;
    assign fail   = bad || (expire && state != SYNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SYNC;
            pre_cnt     <= '0;
            idx         <= '0;
            sum         <= '0;
            timer       <= '0;
            staging     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= '0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            frame_valid <= good;
            frame_err   <= fail;
            if (good) begin
                frame_data <= staged;
                if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
            end
            if (fail) begin
                err_code <= bad ? 2'b01 : 2'b10;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            if (rx_done) timer <= '0;
            else if (run) timer <= expire ? '0 : timer + TW'(1);
            if (expire) begin
                state   <= SYNC;
                pre_cnt <= '0;
            end else if (rx_done) begin
                case (state)
                    SYNC: begin
                        if (current_rx != PREAMBLE_BYTE) pre_cnt <= '0;
                        else if (pre_cnt == 4'(PREAMBLE_LEN - 1)) begin
                            pre_cnt <= '0;
                            idx     <= '0;
                            sum     <= '0;
                            state   <= PAYLOAD;
                        end else pre_cnt <= pre_cnt + 4'd1;
                    end
                    PAYLOAD: begin
                        staging <= staged;
                        sum     <= sum + current_rx;
                        idx     <= idx + IW'(1);
                        if (last) state <= CHECKSUM_EN != 0 ? CHECK : SYNC;
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed frames with hand-computed results for uart_frame_rx.
module tb_uart_frame_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_done;
    logic [7:0]  current_rx;
    logic [79:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_count;
    logic [15:0] err_count;
    int          vecs = 0;
    int          errs = 0;

    localparam logic [79:0] STD = 80'h0A090807060504030201;

    uart_frame_rx #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .current_rx(current_rx),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
        .err_code(err_code), .frame_count(frame_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // byte is sampled on the posedge between the two negedges; returns on the negedge after it
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done    = 1'b1;
        current_rx = b;
        @(negedge clk);
        rx_done    = 1'b0;
    endtask

    task automatic send_pre();
        for (int i = 0; i < 4; i++) send(8'hFF);
    endtask

    task automatic send_std(input logic [7:0] ck);
        send_pre();
        for (int i = 1; i <= 10; i++) send(8'(i));
        send(ck);
    endtask

    initial begin
        rst        = 1'b1;
        rx_done    = 1'b0;
        current_rx = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", frame_data, 80'h0);
        chk("rst_valid", 80'(frame_valid), 80'h0);
        chk("rst_err", 80'(frame_err), 80'h0);
        chk("rst_code", 80'(err_code), 80'h0);
        chk("rst_fcnt", 80'(frame_count), 80'h0);
        chk("rst_ecnt", 80'(err_count), 80'h0);

        send_std(8'h37);
        chk("t1_valid", 80'(frame_valid), 80'h1);
        chk("t1_data", frame_data, STD);
        chk("t1_fcnt", 80'(frame_count), 80'h1);
        chk("t1_ecnt", 80'(err_count), 80'h0);
        @(negedge clk);
        chk("t1_pulse_end", 80'(frame_valid), 80'h0);

        send_std(8'h38);
        chk("t2_err", 80'(frame_err), 80'h1);
        chk("t2_novalid", 80'(frame_valid), 80'h0);
        chk("t2_code", 80'(err_code), 80'h1);
        chk("t2_ecnt", 80'(err_count), 80'h1);
        chk("t2_data", frame_data, STD);
        send_std(8'h37);
        chk("t2_good_valid", 80'(frame_valid), 80'h1);
        chk("t2_fcnt", 80'(frame_count), 80'h2);
        chk("t2_code_kept", 80'(err_code), 80'h1);

        send(8'hFF);
        send(8'hFF);
        send(8'h00);
        send_std(8'h37);
        chk("t3_valid", 80'(frame_valid), 80'h1);
        chk("t3_fcnt", 80'(frame_count), 80'h3);

        send_pre();
        send(8'hFF);
        send(8'h01);
        send(8'hFF);
        for (int i = 3; i <= 9; i++) send(8'(i));
        send(8'h29);
        chk("t4_valid", 80'(frame_valid), 80'h1);
        chk("t4_data", frame_data, 80'h09080706050403FF01FF);
        chk("t4_fcnt", 80'(frame_count), 80'h4);

        send_pre();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        repeat (49) @(negedge clk);
        chk("t5_no_early_err", 80'(frame_err), 80'h0);
        @(negedge clk);
        chk("t5_tmo_err", 80'(frame_err), 80'h1);
        chk("t5_tmo_code", 80'(err_code), 80'h2);
        chk("t5_tmo_ecnt", 80'(err_count), 80'h2);
        @(negedge clk);
        chk("t5_err_end", 80'(frame_err), 80'h0);

        // an idle preamble prefix is dropped silently, so this tail must not form a frame
        send(8'hFF);
        send(8'hFF);
        repeat (60) @(negedge clk);
        send(8'hFF);
        send(8'hFF);
        for (int i = 1; i <= 10; i++) send(8'(i));
        send(8'h37);
        chk("t5_sync_fcnt", 80'(frame_count), 80'h4);
        chk("t5_sync_ecnt", 80'(err_count), 80'h2);

        send_pre();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        repeat (48) @(negedge clk);
        for (int i = 4; i <= 10; i++) send(8'(i));
        send(8'h37);
        chk("t5_edge_valid", 80'(frame_valid), 80'h1);
        chk("t5_edge_fcnt", 80'(frame_count), 80'h5);
        chk("t5_edge_ecnt", 80'(err_count), 80'h2);

        send_pre();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_data", frame_data, 80'h0);
        chk("t6_async_fcnt", 80'(frame_count), 80'h0);
        chk("t6_async_ecnt", 80'(err_count), 80'h0);
        chk("t6_async_code", 80'(err_code), 80'h0);
        @(negedge clk);
        rst = 1'b0;
        send_std(8'h37);
        chk("t6_valid", 80'(frame_valid), 80'h1);
        chk("t6_fcnt", 80'(frame_count), 80'h1);
        chk("t6_data", frame_data, STD);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
